// File: rtl/tx_segment_scheduler.sv
// tx_segment_scheduler: sequences a captured video frame as redundant segment transmissions,
// with inter-frame gap, busy-timeout retry, interleaved status frames and one-deep frame queuing.
module tx_segment_scheduler #(
  parameter int SEGMENTS_PER_FRAME = 720,
  parameter int GAP_CYCLES = 24,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic        clk125MHz,
  input  logic        rstb,
  input  logic        enable,
  input  logic        frame_sync,
  input  logic [2:0]  redundancy,
  input  logic        busy,
  input  logic        status_req,
  output logic        start_sending,
  output logic [15:0] segment_num,
  output logic [7:0]  txid,
  output logic [7:0]  aux,
  output logic        sel_status,
  output logic        status_ack,
  output logic        idle,
  output logic [7:0]  overrun_cnt
);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP} state_t;
  state_t state, state_d;
  logic [7:0] cnt, cnt_d, txid_d, aux_d, ovr_d;
  logic [15:0] seg, seg_d, segn_d;
  logic [2:0] copy, copy_d, red, red_d;
  logic pend, pend_d, in_frame, in_frame_d, last_st, last_st_d, sel_d, ack_d, fs_taken;

  always_comb begin
    state_d = state;
    seg_d = seg;
    copy_d = copy;
    red_d = red;
    pend_d = pend;
    in_frame_d = in_frame;
    last_st_d = last_st;
    txid_d = txid;
    segn_d = segment_num;
    aux_d = aux;
    sel_d = sel_status;
    ack_d = 1'b0;
    ovr_d = overrun_cnt;
    fs_taken = 1'b0;
    case (state)
      IDLE:
        if ((frame_sync || pend) && enable) begin
          state_d = LAUNCH;
          red_d = redundancy == 3'd0 ? 3'd1 : redundancy;
          seg_d = 16'd0;
          copy_d = 3'd0;
          txid_d = txid + 8'd1;
          fs_taken = !pend;
          pend_d = 1'b0;
          in_frame_d = 1'b1;
          last_st_d = 1'b0;
          segn_d = 16'd0;
          aux_d = 8'd0;
          sel_d = 1'b0;
        end else if (status_req && !pend && !frame_sync) begin
          state_d = LAUNCH;
          sel_d = 1'b1;
          segn_d = '1;
          aux_d = '1;
          last_st_d = 1'b1;
        end
      LAUNCH: state_d = WAIT_BUSY;
      WAIT_BUSY:
        if (busy) state_d = WAIT_DONE;
        else if (cnt == 8'(BUSY_TIMEOUT - 1)) state_d = LAUNCH;
      WAIT_DONE:
        if (!busy) begin
          state_d = GAP;
          ack_d = sel_status;
          sel_d = 1'b0;
        end
      GAP:
        if (cnt == 8'(GAP_CYCLES - 1)) begin
          if (status_req && !last_st) begin
            state_d = LAUNCH;
            sel_d = 1'b1;
            segn_d = '1;
            aux_d = '1;
            last_st_d = 1'b1;
          end else if (!in_frame) state_d = IDLE;
          else if (copy < red - 3'd1 || seg < 16'(SEGMENTS_PER_FRAME - 1)) begin
            state_d = LAUNCH;
            last_st_d = 1'b0;
            copy_d = copy < red - 3'd1 ? copy + 3'd1 : 3'd0;
            seg_d = copy < red - 3'd1 ? seg : seg + 16'd1;
            segn_d = seg_d;
            aux_d = {5'd0, copy_d};
          end else begin
            state_d = IDLE;
            in_frame_d = 1'b0;
          end
        end
      default: state_d = IDLE;
    endcase
    // a frame_sync not consumed by a frame start queues one frame; beyond that it is dropped
    if (frame_sync && !fs_taken) begin
      if (pend_d) ovr_d = overrun_cnt == 8'hFF ? overrun_cnt : overrun_cnt + 8'd1;
      else pend_d = 1'b1;
    end
    cnt_d = state_d == state ? cnt + 8'd1 : 8'd0;
  end

  always_ff @(posedge clk125MHz or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      cnt <= 8'd0;
      seg <= 16'd0;
      copy <= 3'd0;
      red <= 3'd0;
      pend <= 1'b0;
      in_frame <= 1'b0;
      last_st <= 1'b0;
      start_sending <= 1'b0;
      segment_num <= 16'd0;
      txid <= 8'd0;
      aux <= 8'd0;
      sel_status <= 1'b0;
      status_ack <= 1'b0;
      idle <= 1'b1;
      overrun_cnt <= 8'd0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      seg <= seg_d;
      copy <= copy_d;
      red <= red_d;
      pend <= pend_d;
      in_frame <= in_frame_d;
      last_st <= last_st_d;
      start_sending <= state == LAUNCH;
      segment_num <= segn_d;
      txid <= txid_d;
      aux <= aux_d;
      sel_status <= sel_d;
      status_ack <= ack_d;
      idle <= state_d == IDLE;
      overrun_cnt <= ovr_d;
    end
  end
endmodule

// File: tb/tb_tx_segment_scheduler.sv
// tb_tx_segment_scheduler: randomized builder timing checked against a launch-sequence model
// derived from frame/segment/copy/status rules.
module tb_tx_segment_scheduler;
  localparam int SPF = 4, GAPC = 5, BTO = 16;
  logic clk125MHz = 1'b0, rstb = 1'b0, enable = 1'b0, frame_sync = 1'b0, busy = 1'b0, status_req = 1'b0;
  logic [2:0] redundancy = 3'd0;
  logic start_sending, sel_status, status_ack, idle;
  logic [15:0] segment_num;
  logic [7:0] txid, aux, overrun_cnt;

  tx_segment_scheduler #(.SEGMENTS_PER_FRAME(SPF), .GAP_CYCLES(GAPC), .BUSY_TIMEOUT(BTO)) dut (
    .clk125MHz(clk125MHz), .rstb(rstb), .enable(enable), .frame_sync(frame_sync),
    .redundancy(redundancy), .busy(busy), .status_req(status_req), .start_sending(start_sending),
    .segment_num(segment_num), .txid(txid), .aux(aux), .sel_status(sel_status),
    .status_ack(status_ack), .idle(idle), .overrun_cnt(overrun_cnt));

  always #4 clk125MHz = ~clk125MHz;

  typedef struct { int seg; int aux; int tx; int sel; } launch_t;
  launch_t obs[$], exp_q[$], mon_l;
  int obs_cyc[$];
  int cyc = 0, acks = 0, n_chk = 0, n_pass = 0, bmode = 1, tx_exp = 0, fs_cyc = 0, b_lat, b_w, r;

  always @(posedge clk125MHz) cyc <= cyc + 1;

  always @(negedge clk125MHz) if (rstb) begin
    if (start_sending) begin
      mon_l.seg = int'(segment_num);
      mon_l.aux = int'(aux);
      mon_l.tx = int'(txid);
      mon_l.sel = int'(sel_status);
      obs.push_back(mon_l);
      obs_cyc.push_back(cyc);
    end
    if (status_ack) acks++;
  end

  // frame builder: bmode 0 never answers, 1 random latency/width, 2 long fixed width
  initial forever begin
    @(negedge clk125MHz);
    if (start_sending && bmode != 0) begin
      b_lat = $urandom_range(1, 4);
      b_w = bmode == 2 ? 10 : $urandom_range(1, 8);
      repeat (b_lat) @(negedge clk125MHz);
      busy = 1'b1;
      repeat (b_w) @(negedge clk125MHz);
      busy = 1'b0;
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input longint got, input longint expv);
    n_chk++;
    if (got == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, expv);
  endtask

  task automatic add_frame(input int red, input int tx, input bit st);
    launch_t l;
    for (int s = 0; s < SPF; s++)
      for (int a = 0; a < (red == 0 ? 1 : red); a++) begin
        l.seg = s; l.aux = a; l.tx = tx; l.sel = 0;
        exp_q.push_back(l);
        if (st) begin
          l.seg = 65535; l.aux = 255; l.sel = 1;
          exp_q.push_back(l);
        end
      end
  endtask

  task automatic pulse_fs();
    @(negedge clk125MHz);
    frame_sync = 1'b1;
    fs_cyc = cyc;
    @(negedge clk125MHz);
    frame_sync = 1'b0;
  endtask

  task automatic start_frame(input int red, input bit st);
    redundancy = 3'(red);
    tx_exp = (tx_exp + 1) % 256;
    add_frame(red, tx_exp, st);
    pulse_fs();
  endtask

  task automatic wait_cnt(input int n);
    int i = 0;
    while (obs.size() < n && i < 5000) begin @(negedge clk125MHz); i++; end
    check("pulse_wait", obs.size() >= n, 1);
  endtask

  task automatic wait_idle();
    int i = 0;
    while (!idle && i < 5000) begin @(negedge clk125MHz); i++; end
    check("idle", idle, 1);
  endtask

  task automatic compare_seq();
    check("launch_count", obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      check($sformatf("seg[%0d]", i), obs[i].seg, exp_q[i].seg);
      check($sformatf("aux[%0d]", i), obs[i].aux, exp_q[i].aux);
      check($sformatf("txid[%0d]", i), obs[i].tx, exp_q[i].tx);
      check($sformatf("sel[%0d]", i), obs[i].sel, exp_q[i].sel);
    end
    obs.delete(); obs_cyc.delete(); exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, start_sending, 0);
    check({tag, "_seg"}, segment_num, 0);
    check({tag, "_txid"}, txid, 0);
    check({tag, "_aux"}, aux, 0);
    check({tag, "_sel"}, sel_status, 0);
    check({tag, "_ack"}, status_ack, 0);
    check({tag, "_idle"}, idle, 1);
    check({tag, "_ovr"}, overrun_cnt, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk125MHz);
    check_reset_outputs("reset");
    rstb = 1'b1;
    enable = 1'b1;
    // redundancy 3: twelve launches in segment/copy order
    start_frame(3, 0);
    wait_cnt(1);
    check("start_latency", obs_cyc[0] - fs_cyc, 2);
    wait_cnt(12);
    wait_idle();
    compare_seq();
    // redundancy 0 behaves as 1
    start_frame(0, 0);
    wait_cnt(4);
    wait_idle();
    compare_seq();
    // status requested throughout a frame
    acks = 0;
    r = $urandom_range(1, 2);
    start_frame(r, 1);
    wait_cnt(1);
    status_req = 1'b1;
    wait_cnt(SPF * r * 2);
    status_req = 1'b0;
    wait_idle();
    check("status_acks", acks, SPF * r);
    compare_seq();
    // status from idle
    acks = 0;
    mon_l.seg = 65535; mon_l.aux = 255; mon_l.tx = tx_exp; mon_l.sel = 1;
    exp_q.push_back(mon_l);
    status_req = 1'b1;
    wait_cnt(1);
    status_req = 1'b0;
    wait_idle();
    check("idle_status_ack", acks, 1);
    compare_seq();
    // builder never answers: retries every BUSY_TIMEOUT+1 cycles
    bmode = 0;
    start_frame(1, 0);
    wait_cnt(5);
    for (int i = 1; i < 5; i++) check($sformatf("retry_period[%0d]", i), obs_cyc[i] - obs_cyc[i-1], BTO + 1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("retry_seg[%0d]", i), obs[i].seg, 0);
      check($sformatf("retry_aux[%0d]", i), obs[i].aux, 0);
      check($sformatf("retry_txid[%0d]", i), obs[i].tx, tx_exp);
    end
    bmode = 1;
    wait_idle();
    check("retry_last_seg", obs[obs.size()-1].seg, SPF - 1);
    obs.delete(); obs_cyc.delete(); exp_q.delete();
    // three frame_syncs mid-frame: one pending frame, two overruns
    start_frame(1, 0);
    wait_cnt(1);
    repeat (3) pulse_fs();
    tx_exp = (tx_exp + 1) % 256;
    add_frame(1, tx_exp, 0);
    wait_cnt(2 * SPF);
    wait_idle();
    check("overrun_cnt", overrun_cnt, 2);
    compare_seq();
    // run frames until txid wraps to 0
    do begin
      r = $urandom_range(0, 2);
      start_frame(r, 0);
      wait_cnt(SPF * (r == 0 ? 1 : r));
      wait_idle();
      compare_seq();
    end while (tx_exp != 0);
    // reset while waiting for busy to fall
    bmode = 2;
    start_frame(2, 0);
    wait_cnt(1);
    for (int i = 0; i < 200 && !busy; i++) @(negedge clk125MHz);
    check("busy_seen", busy, 1);
    @(negedge clk125MHz);
    rstb = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk125MHz);
    rstb = 1'b1;
    for (int i = 0; i < 200 && busy; i++) @(negedge clk125MHz);
    bmode = 1;
    obs.delete(); obs_cyc.delete(); exp_q.delete();
    tx_exp = 0;
    start_frame(1, 0);
    wait_cnt(SPF);
    wait_idle();
    compare_seq();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
